mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sits directly downstream of the cpu block; consumes its imem_* and dmem_* request ports.
- Serializes both sides onto one single-word backing memory port.
- Holds each granted request stable until the memory responds, then returns a registered one-cycle response with registered read data to the winning side.
- Fixed D-side priority with a starvation guard on the I side.

Parameters:
- STARVE_LIMIT, 4, consecutive D grants taken while I is pending before I is forced next. Legal range 1..15.
- ADDR_W, 32, address and data width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- imem_read  input  1  I-side read request
- imem_address  input  ADDR_W  I-side address
- imem_resp  output  1  I-side done pulse
- imem_rdata  output  ADDR_W  I-side read data
- dmem_read  input  1  D-side read request
- dmem_write  input  1  D-side write request
- dmem_wmask  input  4  D-side byte-enable
- dmem_address  input  ADDR_W  D-side address
- dmem_wdata  input  ADDR_W  D-side write data
- dmem_resp  output  1  D-side done pulse
- dmem_rdata  output  ADDR_W  D-side read data
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_wmask  output  4  memory byte-enable
- mem_address  output  ADDR_W  memory address
- mem_wdata  output  ADDR_W  memory write data
- mem_resp  input  1  memory done
- mem_rdata  input  ADDR_W  memory read data

Behaviour:
- Reset: asynchronous on rst high.
  - State IDLE; starve_cnt=0.
  - All outputs 0, including rdata registers.
- FSM states: IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
- IDLE:
  - d_req = dmem_read|dmem_write.
  - If d_req and starve_cnt<STARVE_LIMIT, go to SERVE_D.
  - Else if imem_read, go to SERVE_I.
  - Else if d_req, go to SERVE_D.
  - On grant, latch the request (address, wdata, wmask, read/write) into internal registers.
- SERVE_x:
  - mem_* driven from the latched registers; stable until mem_resp regardless of requester input changes.
  - I grants drive mem_read=1, mem_write=0, mem_wmask=0.
  - D grants drive mem_read or mem_write as latched. If both were set, write wins: mem_write=1, mem_read=0.
  - On mem_resp: capture mem_rdata into the x-side rdata register (reads only) and go to DONE_x.
- DONE_x:
  - x_resp=1 for exactly this cycle; mem_read=mem_write=0.
  - Next state is always IDLE. No grant is evaluated in DONE, so the requester has one cycle to drop its request.
- Latency: memory request is asserted the cycle after the request is seen in IDLE. Response comes 1 cycle after mem_resp. Minimum round trip is 3 cycles with zero-wait memory.
- rdata holds its value until the next read completion on that side. Writes do not change dmem_rdata.
- starve_cnt:
  - Increments on each D grant taken while imem_read=1, saturating at STARVE_LIMIT.
  - Clears to 0 on each I grant.
  - Unchanged otherwise.
- Simultaneous I and D in IDLE: D wins unless starve_cnt==STARVE_LIMIT, then I wins.
- mem_resp in IDLE or DONE is ignored.
- Reset mid-transaction: strobes drop immediately, the transaction is abandoned, and no resp is issued.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - starve_cnt is removed.
  - A 1-bit last_grant (reset to I) decides simultaneous requests: the side not granted last wins.
  - Single requests are granted as usual, and last_grant updates on every grant.
- Undefined: fixed D priority with the starvation guard as above.

Test Plan:
- Lone I read of 0x0000_0040, memory returns 0xDEAD_BEEF after 2 wait cycles -> mem_read asserted 1 cycle after request. imem_resp pulses 1 cycle after mem_resp with imem_rdata=0xDEAD_BEEF; dmem_resp stays 0.
- D write of 0x1234_5678, wmask=4'b0011, addr 0x100; dmem_wdata toggled during the wait -> mem_wdata stays 0x1234_5678 and mem_wmask stays 0011 until mem_resp; dmem_resp pulses once; dmem_rdata unchanged.
- I and D both held continuously, STARVE_LIMIT=4, zero-wait memory -> grant order D,D,D,D,I,D,D,D,D,I. With ARB_ROUND_ROBIN_EN: D,I,D,I,...
- rst asserted 1 cycle into SERVE_D -> mem_write/mem_read drop the same cycle (asynchronously); no dmem_resp; state IDLE after release.
- mem_resp pulsed while idle, then requester holds imem_read through DONE_I -> no response generated for the stray pulse; exactly one imem_resp, and re-grant only from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serializes the CPU instruction-side (imem_*) and data-side (dmem_*) request
// ports onto a single one-word backing memory port. A granted request is
// latched and held stable on mem_* until mem_resp. The winning side then gets
// a one-cycle resp pulse and registered read data.
//
// Arbitration (default build): fixed D priority. A saturating starvation
// counter forces an I grant after STARVE_LIMIT consecutive D grants taken
// while I was waiting.
// Optional macro ARB_ROUND_ROBIN_EN: the starvation counter is replaced by a
// 1-bit last_grant. On simultaneous requests, the side not granted last wins.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   imem_read/address              I-side read request
//   imem_resp/rdata                I-side done pulse / read data
//   dmem_read/write/wmask/address/wdata   D-side request
//   dmem_resp/rdata                D-side done pulse / read data
//   mem_read/write/wmask/address/wdata    backing memory request
//   mem_resp/rdata                 backing memory done / read data
//
// state   | meaning
// IDLE    | no transaction; arbitrate and latch the winning request
// SERVE_I | I read presented on mem_*, waiting for mem_resp
// SERVE_D | D read/write presented on mem_*, waiting for mem_resp
// DONE_I  | imem_resp pulse; requester gets one cycle to drop its request
// DONE_D  | dmem_resp pulse; requester gets one cycle to drop its request

module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_read,
   input  logic [ADDR_W-1:0] imem_address,
   output logic              imem_resp,
   output logic [ADDR_W-1:0] imem_rdata,
   input  logic              dmem_read,
   input  logic              dmem_write,
   input  logic [3:0]        dmem_wmask,
   input  logic [ADDR_W-1:0] dmem_address,
   input  logic [ADDR_W-1:0] dmem_wdata,
   output logic              dmem_resp,
   output logic [ADDR_W-1:0] dmem_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [3:0]        mem_wmask,
   output logic [ADDR_W-1:0] mem_address,
   output logic [ADDR_W-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [ADDR_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SERVE_I = 3'd1,
      SERVE_D = 3'd2,
      DONE_I  = 3'd3,
      DONE_D  = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic              d_req;
   logic              grant_i, grant_d;

   logic [ADDR_W-1:0] lat_addr;
   logic [ADDR_W-1:0] lat_wdata;
   logic [3:0]        lat_wmask;
   logic              lat_read;
   logic              lat_write;

   assign d_req = dmem_read | dmem_write;

`ifdef ARB_ROUND_ROBIN_EN
   // 0 = I granted last, 1 = D granted last
   logic last_grant;

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE) begin
         if (d_req && imem_read) begin
            grant_i = last_grant;
            grant_d = ~last_grant;
         end else if (d_req) begin
            grant_d = 1'b1;
         end else if (imem_read) begin
            grant_i = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b0;
      end else if (grant_d) begin
         last_grant <= 1'b1;
      end else if (grant_i) begin
         last_grant <= 1'b0;
      end
   end
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt;

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE) begin
         if (d_req && (starve_cnt < LIMIT)) begin
            grant_d = 1'b1;
         end else if (imem_read) begin
            grant_i = 1'b1;
         end else if (d_req) begin
            grant_d = 1'b1;
         end
      end
   end

   // Only D grants that jump ahead of a waiting I count toward starvation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 4'd0;
      end else if (grant_i) begin
         starve_cnt <= 4'd0;
      end else if (grant_d && imem_read && (starve_cnt < LIMIT)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request latch; a D request with both read and write set is stored as a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wmask <= 4'd0;
         lat_read  <= 1'b0;
         lat_write <= 1'b0;
      end else if (grant_d) begin
         lat_addr  <= dmem_address;
         lat_wdata <= dmem_wdata;
         lat_wmask <= dmem_wmask;
         lat_read  <= dmem_read & ~dmem_write;
         lat_write <= dmem_write;
      end else if (grant_i) begin
         lat_addr  <= imem_address;
         lat_wdata <= '0;
         lat_wmask <= 4'd0;
         lat_read  <= 1'b1;
         lat_write <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_rdata <= '0;
         dmem_rdata <= '0;
      end else begin
         if (state == SERVE_I && mem_resp) begin
            imem_rdata <= mem_rdata;
         end
         if (state == SERVE_D && mem_resp && lat_read) begin
            dmem_rdata <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_wmask   = 4'd0;
      mem_address = '0;
      mem_wdata   = '0;
      imem_resp   = 1'b0;
      dmem_resp   = 1'b0;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_nxt = SERVE_D;
            end else if (grant_i) begin
               state_nxt = SERVE_I;
            end
         end
         SERVE_I: begin
            mem_read    = 1'b1;
            mem_address = lat_addr;
            if (mem_resp) begin
               state_nxt = DONE_I;
            end
         end
         SERVE_D: begin
            mem_read    = lat_read;
            mem_write   = lat_write;
            mem_wmask   = lat_wmask;
            mem_address = lat_addr;
            mem_wdata   = lat_wdata;
            if (mem_resp) begin
               state_nxt = DONE_D;
            end
         end
         DONE_I: begin
            imem_resp = 1'b1;
            state_nxt = IDLE;
         end
         DONE_D: begin
            dmem_resp = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_read;
   logic [31:0] imem_address;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        dmem_read, dmem_write;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_address, dmem_wdata;
   logic        dmem_resp;
   logic [31:0] dmem_rdata;
   logic        mem_read, mem_write;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_address, mem_wdata;
   logic        mem_resp;
   logic [31:0] mem_rdata;

   int passed = 0;
   int total  = 0;

   mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .imem_read(imem_read), .imem_address(imem_address),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wmask(dmem_wmask),
      .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
      .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dw;
      logic [3:0]  dm;
      logic [31:0] da;
      logic [31:0] dd;
      logic        mr;
      logic [31:0] mrd;
      logic        e_rd;
      logic        e_wr;
      logic [3:0]  e_wm;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      logic        e_iresp;
      logic        e_dresp;
      logic [31:0] e_ird;
      logic [31:0] e_drd;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs[NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic chk_outs(input string p, input vec_t v);
      chk({p, ".mem_read"},    32'(mem_read),    32'(v.e_rd));
      chk({p, ".mem_write"},   32'(mem_write),   32'(v.e_wr));
      chk({p, ".mem_wmask"},   32'(mem_wmask),   32'(v.e_wm));
      chk({p, ".mem_address"}, mem_address,      v.e_addr);
      chk({p, ".mem_wdata"},   mem_wdata,        v.e_wd);
      chk({p, ".imem_resp"},   32'(imem_resp),   32'(v.e_iresp));
      chk({p, ".dmem_resp"},   32'(dmem_resp),   32'(v.e_dresp));
      chk({p, ".imem_rdata"},  imem_rdata,       v.e_ird);
      chk({p, ".dmem_rdata"},  dmem_rdata,       v.e_drd);
   endtask

   task automatic drive(input vec_t v);
      imem_read    = v.ir;
      imem_address = v.ia;
      dmem_read    = v.dr;
      dmem_write   = v.dw;
      dmem_wmask   = v.dm;
      dmem_address = v.da;
      dmem_wdata   = v.dd;
      mem_resp     = v.mr;
      mem_rdata    = v.mrd;
   endtask

   task automatic idle_inputs();
      imem_read = 0; imem_address = 0;
      dmem_read = 0; dmem_write = 0; dmem_wmask = 0;
      dmem_address = 0; dmem_wdata = 0;
      mem_resp = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vec_t zero_exp;
      logic exp_d[10];
      int   n;
      int   cyc;
      logic got_d;

      //          ir ia          dr dw dm     da           dd            mr mrd           rd wr wm     addr         wd            ir dr ird           drd
      vecs[0]  = '{1, 32'h40,    0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        32'h0};
      vecs[1]  = '{1, 32'h40,    0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        1, 0, 4'h0, 32'h40,  32'h0,        0, 0, 32'h0,        32'h0};
      vecs[2]  = '{1, 32'h40,    0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        1, 0, 4'h0, 32'h40,  32'h0,        0, 0, 32'h0,        32'h0};
      vecs[3]  = '{1, 32'h40,    0, 0, 4'h0, 32'h0,   32'h0,        1, 32'hDEADBEEF, 1, 0, 4'h0, 32'h40,  32'h0,        0, 0, 32'h0,        32'h0};
      vecs[4]  = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF, 32'h0};
      vecs[5]  = '{0, 32'h0,     0, 1, 4'h3, 32'h100, 32'h12345678, 0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, 32'h0};
      vecs[6]  = '{0, 32'h0,     0, 1, 4'hF, 32'h200, 32'hFFFFFFFF, 0, 32'h0,        0, 1, 4'h3, 32'h100, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[7]  = '{0, 32'h0,     0, 1, 4'hF, 32'h200, 32'hFFFFFFFF, 1, 32'hAAAA5555, 0, 1, 4'h3, 32'h100, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h0};
      vecs[8]  = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF, 32'h0};
      vecs[9]  = '{0, 32'h0,     1, 1, 4'hF, 32'h300, 32'h11,       0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, 32'h0};
      vecs[10] = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h77,       0, 1, 4'hF, 32'h300, 32'h11,       0, 0, 32'hDEADBEEF, 32'h0};
      vecs[11] = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF, 32'h0};
      vecs[12] = '{0, 32'h0,     1, 0, 4'h0, 32'h400, 32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, 32'h0};
      vecs[13] = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        1, 32'hCAFEF00D, 1, 0, 4'h0, 32'h400, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0};
      vecs[14] = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF, 32'hCAFEF00D};
      vecs[15] = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h5,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, 32'hCAFEF00D};
      vecs[16] = '{1, 32'h80,    0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, 32'hCAFEF00D};
      vecs[17] = '{1, 32'h80,    0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h0BADC0DE, 1, 0, 4'h0, 32'h80,  32'h0,        0, 0, 32'hDEADBEEF, 32'hCAFEF00D};
      vecs[18] = '{1, 32'h80,    0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0BADC0DE, 32'hCAFEF00D};
      vecs[19] = '{1, 32'h80,    0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0BADC0DE, 32'hCAFEF00D};
      vecs[20] = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        1, 32'h22,       1, 0, 4'h0, 32'h80,  32'h0,        0, 0, 32'h0BADC0DE, 32'hCAFEF00D};
      vecs[21] = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h22,       32'hCAFEF00D};
      vecs[22] = '{0, 32'h0,     0, 0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h22,       32'hCAFEF00D};

      zero_exp = '{0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0,
                   0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0};

      // Reset with busy-looking inputs: every output must still read 0.
      rst = 1'b1;
      imem_read = 1; imem_address = 32'hFFFF_FFFF;
      dmem_read = 1; dmem_write = 1; dmem_wmask = 4'hF;
      dmem_address = 32'hFFFF_FFFF; dmem_wdata = 32'hFFFF_FFFF;
      mem_resp = 1; mem_rdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      #1 chk_outs("reset", zero_exp);
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;

      // Table: inputs applied at negedge, outputs (all register-driven) checked 1ns later.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1 chk_outs($sformatf("v%0d", i), vecs[i]);
      end

      // Both sides held continuously with zero-wait memory; record grant order.
      for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_d[i] = (i % 2) == 0;
`else
         exp_d[i] = (i % 5) != 4;
`endif
      end
      do_reset();
      imem_read = 1; imem_address = 32'h1000;
      dmem_read = 1; dmem_address = 32'h2000;
      mem_resp = 1; mem_rdata = 32'h0;
      n = 0;
      cyc = 0;
      while (n < 10 && cyc < 100) begin
         @(negedge clk);
         #1;
         if (mem_read) begin
            got_d = (mem_address == 32'h2000);
            chk($sformatf("grant%0d_is_d", n), 32'(got_d), 32'(exp_d[n]));
            n++;
         end
         cyc++;
      end
      if (n < 10) begin
         total++;
         $display("FAIL grant_order_timeout: got %0d grants expected 10", n);
      end

      // Reset one cycle into SERVE_D: strobes drop at once, no resp afterwards.
      do_reset();
      @(negedge clk);
      dmem_write = 1; dmem_wmask = 4'hF;
      dmem_address = 32'h500; dmem_wdata = 32'hABCD;
      #1 chk("rstmid.pre_idle_write", 32'(mem_write), 32'd0);
      @(negedge clk);
      #1 chk("rstmid.serve_write", 32'(mem_write), 32'd1);
      @(negedge clk);
      chk("rstmid.serve2_write", 32'(mem_write), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid.async_write", 32'(mem_write), 32'd0);
      chk("rstmid.async_read", 32'(mem_read), 32'd0);
      chk("rstmid.async_wmask", 32'(mem_wmask), 32'd0);
      idle_inputs();
      mem_resp = 1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rstmid.post%0d_dresp", i), 32'(dmem_resp), 32'd0);
         chk($sformatf("rstmid.post%0d_write", i), 32'(mem_write), 32'd0);
         chk($sformatf("rstmid.post%0d_read", i), 32'(mem_read), 32'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
